// File: rtl/ov7670_config_sequencer.sv
// OV7670 configuration sequencer.
// Walks the register-init ROM from address 0 and hands each {reg,value}
// word to the SCCB write master. Two sentinel words steer the walk:
//   16'hFFF0 : pause for DELAY_CYCLES clocks (sensor settle after soft reset)
//   16'hFFFF : end of table, park in DONE until the next start
module ov7670_config_sequencer #(
  parameter int DELAY_CYCLES = 240000,
  parameter int CNT_W        = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_dout,
  output logic        sccb_start,
  output logic [7:0]  sccb_reg,
  output logic [7:0]  sccb_data,
  input  logic        sccb_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_DELAY,
    S_DONE
  } state_t;

  localparam logic [15:0]      WORD_DELAY = 16'hFFF0;
  localparam logic [15:0]      WORD_END   = 16'hFFFF;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DELAY_CYCLES - 1);

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt;
  logic             addr_clr, addr_inc;
  logic             cnt_clr, cnt_inc;
  logic             wr_latch;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // Next-state decode and datapath strobes. sccb_start is decoded
  // directly from SEND && ready so it can never fire while the master
  // is busy, and since SEND always exits on the same cycle the pulse is
  // exactly one clock wide.
  always_comb begin
    nxt        = state;
    addr_clr   = 1'b0;
    addr_inc   = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    wr_latch   = 1'b0;
    sccb_start = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          addr_clr = 1'b1;
          nxt      = S_FETCH;
        end
      end
      // ROM is registered: address is stable here, data lands next cycle
      S_FETCH: nxt = S_DECODE;
      S_DECODE: begin
        if (rom_dout == WORD_END) begin
          nxt = S_DONE;
        end else if (rom_dout == WORD_DELAY) begin
          cnt_clr = 1'b1;
          nxt     = S_DELAY;
        end else begin
          wr_latch = 1'b1;
          nxt      = S_SEND;
        end
      end
      S_SEND: begin
        if (sccb_ready) begin
          sccb_start = 1'b1;
          nxt        = S_WAIT_ACK;
        end
      end
      // Master drops ready once it has taken the request
      S_WAIT_ACK: begin
        if (!sccb_ready) nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (sccb_ready) begin
          addr_inc = 1'b1;
          nxt      = S_FETCH;
        end
      end
      // Counter runs 0..DELAY_CYCLES-1, one value per cycle in DELAY
      S_DELAY: begin
        if (cnt == CNT_LAST) begin
          addr_inc = 1'b1;
          nxt      = S_FETCH;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  // ROM address, delay counter and the held write word. The address is
  // 8 bits and wraps 255 -> 0 on its own; the ROM's FFFF default is what
  // normally stops the walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr  <= '0;
      cnt       <= '0;
      sccb_reg  <= '0;
      sccb_data <= '0;
    end else begin
      if (addr_clr)      rom_addr <= '0;
      else if (addr_inc) rom_addr <= rom_addr + 8'd1;

      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);

      // Held from DECODE through the whole write until the next DECODE
      if (wr_latch) {sccb_reg, sccb_data} <= rom_dout;
    end
  end

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Bench for ov7670_config_sequencer: registered ROM model, randomized SCCB
// master latency, reference walk of the ROM table built from plain rules.
module tb_ov7670_config_sequencer;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_dout = 16'hFFFF;
  logic        sccb_start;
  logic [7:0]  sccb_reg, sccb_data;
  logic        sccb_ready = 1'b1;
  logic        busy, done;

  ov7670_config_sequencer #(.DELAY_CYCLES(D), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr),
    .rom_dout(rom_dout), .sccb_start(sccb_start), .sccb_reg(sccb_reg),
    .sccb_data(sccb_data), .sccb_ready(sccb_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ROM model: registered read, one clock latency
  logic [15:0] rom [256];
  always @(posedge clk) rom_dout <= rom[rom_addr];

  // SCCB master model
  bit master_en = 1'b0;
  int lat_lo = 4, lat_hi = 4;
  initial begin
    forever begin
      @(negedge clk);
      if (master_en && sccb_start && sccb_ready) begin
        int lat;
        lat = int'($urandom_range(lat_hi, lat_lo));
        @(posedge clk); #1 sccb_ready = 1'b0;
        repeat (lat) @(posedge clk);
        #1 sccb_ready = 1'b1;
      end
    end
  end

  // Monitor: records issued writes and protocol observations
  logic [15:0] wr_q[$];
  int viol = 0, done_rises = 0, dly_cnt = 0, dly_addr = 999;
  bit prev_start = 1'b0, prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (sccb_start) begin
        wr_q.push_back({sccb_reg, sccb_data});
        if (!sccb_ready) viol++;
        if (prev_start)  viol++;
      end
      if (done && !prev_done) done_rises++;
      if (busy && rom_addr == dly_addr) dly_cnt++;
    end
    prev_start = sccb_start;
    prev_done  = done;
  end

  // Reference model: walk the table by its rules
  logic [15:0] exp_q[$];
  int exp_dly, exp_end;
  function automatic void build_ref();
    int a;
    exp_q.delete(); exp_dly = 0; exp_end = -1; a = 0;
    for (int n = 0; n < 256; n++) begin
      if (rom[a] == 16'hFFFF) begin exp_end = a; break; end
      if (rom[a] == 16'hFFF0) exp_dly++;
      else exp_q.push_back(rom[a]);
      a = (a + 1) % 256;
    end
  endfunction

  function automatic int write_diffs();
    int bad;
    bad = (wr_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
      if (wr_q[i] !== exp_q[i]) bad++;
    return bad;
  endfunction

  function automatic logic [15:0] rand_word();
    logic [7:0] r;
    r = 8'($urandom_range(254, 0));
    return {r, 8'($urandom)};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
  endtask

  task automatic clear_mon();
    wr_q.delete(); viol = 0; done_rises = 0; dly_cnt = 0;
  endtask

  task automatic do_reset();
    master_en = 1'b0; start = 1'b0; sccb_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    clear_mon();
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin to = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (rom_addr !== 8'd0)   begin errors++; $display("FAIL reset_addr got %h want 00", rom_addr); end
    if (sccb_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", sccb_start); end
    if (sccb_reg !== 8'd0)   begin errors++; $display("FAIL reset_reg got %h want 00", sccb_reg); end
    if (sccb_data !== 8'd0)  begin errors++; $display("FAIL reset_data got %h want 00", sccb_data); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got %b want 0", done); end
  endtask

  task automatic test_basic();
    bit to;
    do_reset(); clear_rom();
    rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1204;
    build_ref();
    dly_addr = 1; lat_lo = 4; lat_hi = 4; master_en = 1'b1;
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
    wait_done(500, to);
    checks += 6;
    if (to) begin errors++; $display("FAIL basic_timeout got no done want done"); end
    if (write_diffs() != 0) begin errors++; $display("FAIL basic_writes got %0d writes want %0d", wr_q.size(), exp_q.size()); end
    if (dly_cnt != D + 2) begin errors++; $display("FAIL basic_delay got %0d want %0d", dly_cnt, D + 2); end
    if (rom_addr !== 8'(exp_end)) begin errors++; $display("FAIL basic_addr got %0d want %0d", rom_addr, exp_end); end
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b want 0", busy); end
    if (viol != 0) begin errors++; $display("FAIL basic_proto got %0d want 0", viol); end
  endtask

  task automatic test_stall();
    bit to;
    int bad;
    logic [15:0] w;
    do_reset(); clear_rom();
    w = rand_word(); rom[0] = w;
    build_ref();
    sccb_ready = 1'b0;
    pulse_start();
    repeat (2) @(negedge clk);   // now held in SEND
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sccb_start !== 1'b0) bad++;
    end
    checks += 2;
    if (bad != 0) begin errors++; $display("FAIL stall_start got %0d pulses want 0", bad); end
    if ({sccb_reg, sccb_data} !== w) begin errors++; $display("FAIL stall_word got %h want %h", {sccb_reg, sccb_data}, w); end
    master_en = 1'b1; lat_lo = 3; lat_hi = 3;
    @(posedge clk); #1 sccb_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (sccb_start !== 1'b1) begin errors++; $display("FAIL stall_release got %b want 1", sccb_start); end
    @(negedge clk);
    checks++;
    if (sccb_start !== 1'b0) begin errors++; $display("FAIL stall_single got %b want 0", sccb_start); end
    wait_done(200, to);
    checks += 3;
    if (to) begin errors++; $display("FAIL stall_timeout got no done want done"); end
    if (write_diffs() != 0) begin errors++; $display("FAIL stall_writes got %0d writes want 1", wr_q.size()); end
    if ({sccb_reg, sccb_data} !== w) begin errors++; $display("FAIL stall_hold got %h want %h", {sccb_reg, sccb_data}, w); end
  endtask

  task automatic test_start_ignored();
    bit to;
    do_reset(); clear_rom();
    for (int i = 0; i < 5; i++) rom[i] = rand_word();
    build_ref();
    lat_lo = 1; lat_hi = 6; master_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 300 && wr_q.size() < 3; i++) @(negedge clk);
    pulse_start();
    wait_done(500, to);
    repeat (5) @(negedge clk);
    checks += 4;
    if (to) begin errors++; $display("FAIL ignore_timeout got no done want done"); end
    if (write_diffs() != 0) begin errors++; $display("FAIL ignore_writes got %0d writes want %0d", wr_q.size(), exp_q.size()); end
    if (done_rises != 1) begin errors++; $display("FAIL ignore_done_rises got %0d want 1", done_rises); end
    if (rom_addr !== 8'(exp_end)) begin errors++; $display("FAIL ignore_addr got %0d want %0d", rom_addr, exp_end); end
  endtask

  task automatic test_reset_mid_delay();
    bit to;
    do_reset(); clear_rom();
    rom[0] = 16'hFFF0; rom[1] = rand_word();
    build_ref();
    dly_addr = 0; lat_lo = 2; lat_hi = 2; master_en = 1'b1;
    pulse_start();
    repeat (7) @(posedge clk);   // DELAY with counter at 5
    #1 rst_n = 1'b0;
    #1;
    checks += 3;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got busy=%b done=%b want 0 0", busy, done); end
    if (rom_addr !== 8'd0 || sccb_start !== 1'b0) begin errors++; $display("FAIL rst_mid_addr got %h start=%b want 00 0", rom_addr, sccb_start); end
    if (sccb_reg !== 8'd0 || sccb_data !== 8'd0) begin errors++; $display("FAIL rst_mid_word got %h%h want 0000", sccb_reg, sccb_data); end
    @(negedge clk) rst_n = 1'b1;
    clear_mon();
    pulse_start();
    wait_done(300, to);
    checks += 3;
    if (to) begin errors++; $display("FAIL rst_mid_timeout got no done want done"); end
    if (dly_cnt != D + 2) begin errors++; $display("FAIL rst_mid_delay got %0d want %0d", dly_cnt, D + 2); end
    if (write_diffs() != 0) begin errors++; $display("FAIL rst_mid_writes got %0d writes want %0d", wr_q.size(), exp_q.size()); end
  endtask

  task automatic test_empty();
    do_reset(); clear_rom();
    master_en = 1'b1;
    pulse_start();
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL empty_early got %b want 0", done); end
    @(negedge clk);
    repeat (3) @(negedge clk);
    checks += 3;
    if (done !== 1'b1) begin errors++; $display("FAIL empty_done got %b want 1", done); end
    if (wr_q.size() != 0) begin errors++; $display("FAIL empty_writes got %0d want 0", wr_q.size()); end
    if (rom_addr !== 8'd0) begin errors++; $display("FAIL empty_addr got %0d want 0", rom_addr); end
  endtask

  task automatic test_empty_timing();
    do_reset(); clear_rom();
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL empty_latency got %b want 1", done); end
  endtask

  task automatic test_full_rom();
    bit to;
    int p;
    do_reset(); clear_rom();
    p = int'($urandom_range(74, 1));
    for (int i = 0; i < 76; i++) rom[i] = (i == p) ? 16'hFFF0 : rand_word();
    build_ref();
    dly_addr = p; lat_lo = 1; lat_hi = 8; master_en = 1'b1;
    pulse_start();
    wait_done(5000, to);
    checks += 6;
    if (to) begin errors++; $display("FAIL full_timeout got no done want done"); end
    if (wr_q.size() != 75) begin errors++; $display("FAIL full_count got %0d want 75", wr_q.size()); end
    if (write_diffs() != 0) begin errors++; $display("FAIL full_writes got %0d diffs want 0", write_diffs()); end
    if (dly_cnt != D + 2) begin errors++; $display("FAIL full_delay got %0d want %0d", dly_cnt, D + 2); end
    if (rom_addr !== 8'd76) begin errors++; $display("FAIL full_addr got %0d want 76", rom_addr); end
    if (viol != 0) begin errors++; $display("FAIL full_proto got %0d want 0", viol); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) rom[i] = rand_word();
    dly_addr = 999; lat_lo = 1; lat_hi = 1; master_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 4000 && wr_q.size() < 257; i++) @(negedge clk);
    checks++;
    if (wr_q.size() < 257) begin
      errors++; $display("FAIL wrap_timeout got %0d writes want 257", wr_q.size());
    end else begin
      checks += 3;
      if (wr_q[255] !== rom[255]) begin errors++; $display("FAIL wrap_last got %h want %h", wr_q[255], rom[255]); end
      if (wr_q[256] !== rom[0]) begin errors++; $display("FAIL wrap_first got %h want %h", wr_q[256], rom[0]); end
      if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL wrap_running got busy=%b done=%b want 1 0", busy, done); end
    end
    do_reset();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_rom();
    test_reset();
    test_basic();
    test_stall();
    test_start_ignored();
    test_reset_mid_delay();
    test_empty();
    test_empty_timing();
    test_full_rom();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
